// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA colour stage and its command decoder.
// Timing bounds, opcodes, reset defaults and the colour/box payload types.
package vga_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned H_ACT_START = 144;
  localparam int unsigned H_ACT_END   = 783;
  localparam int unsigned V_ACT_START = 35;
  localparam int unsigned V_ACT_END   = 514;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned V_TOTAL     = 525;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 2500000;

  localparam logic [7:0] OP_SET_FG  = 8'h01;
  localparam logic [7:0] OP_SET_BG  = 8'h02;
  localparam logic [7:0] OP_SET_BOX = 8'h03;
  localparam logic [7:0] OP_CLEAR   = 8'h04;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
  } box_t;

  localparam rgb_t DEF_FG  = 12'hFFF;
  localparam rgb_t DEF_BG  = 12'h000;
  localparam box_t DEF_BOX = '{x0: 8'd0, y0: 8'd0, x1: 8'd159, y1: 8'd119};

  typedef enum logic {ST_IDLE, ST_PAYLOAD} cmd_state_e;

  // Inclusive unsigned cell test; an inverted box simply never matches.
  function automatic logic in_box(input box_t b, input logic [7:0] bx, input logic [7:0] by);
    return (bx >= b.x0) && (bx <= b.x1) && (by >= b.y0) && (by <= b.y1);
  endfunction

endpackage

// File: rtl/vga_pixel_gen_if.sv
// Counter/sync inputs, UART byte stream and colour/status outputs of the pixel stage.
interface vga_pixel_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             hsync_in;
  logic             vsync_in;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             hsync_out;
  logic             vsync_out;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;
  logic             cmd_busy;
  logic             cmd_error;

  modport slave (
    input  h_count, v_count, hsync_in, vsync_in, rx_data, rx_valid,
    output hsync_out, vsync_out, red, green, blue, cmd_busy, cmd_error
  );

  modport master (
    output h_count, v_count, hsync_in, vsync_in, rx_data, rx_valid,
    input  hsync_out, vsync_out, red, green, blue, cmd_busy, cmd_error
  );

endinterface

// File: rtl/vga_cmd_decoder.sv
// Byte-command FSM: stages payload bytes, guards against stalls, and holds the
// shadow colours/box plus the pending flag consumed by the frame-start commit.
module vga_cmd_decoder
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       commit_c,
  output rgb_t       shadow_fg,
  output rgb_t       shadow_bg,
  output box_t       shadow_box,
  output logic       pending,
  output logic       busy,
  output logic       error
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  cmd_state_e       state, state_nxt;
  logic [7:0]       op, op_nxt;
  logic [2:0]       left, left_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [3:0][7:0]  stage, stage_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  rgb_t             fg_nxt, bg_nxt;
  box_t             box_nxt;
  logic             pending_nxt, error_nxt;
  logic [3:0][7:0]  bytes_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op         <= '0;
      left       <= '0;
      idx        <= '0;
      stage      <= '0;
      gap        <= '0;
      shadow_fg  <= DEF_FG;
      shadow_bg  <= DEF_BG;
      shadow_box <= DEF_BOX;
      pending    <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      left       <= left_nxt;
      idx        <= idx_nxt;
      stage      <= stage_nxt;
      gap        <= gap_nxt;
      shadow_fg  <= fg_nxt;
      shadow_bg  <= bg_nxt;
      shadow_box <= box_nxt;
      pending    <= pending_nxt;
      busy       <= (state_nxt != ST_IDLE);
      error      <= error_nxt;
    end
  end

  // Next-state, staging and shadow update; a completion in the commit cycle re-arms pending.
  always_comb begin
    state_nxt   = state;
    op_nxt      = op;
    left_nxt    = left;
    idx_nxt     = idx;
    stage_nxt   = stage;
    gap_nxt     = gap;
    fg_nxt      = shadow_fg;
    bg_nxt      = shadow_bg;
    box_nxt     = shadow_box;
    error_nxt   = 1'b0;
    pending_nxt = commit_c ? 1'b0 : pending;
    bytes_c      = stage;
    bytes_c[idx] = rx_data;

    unique case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          op_nxt    = rx_data;
          idx_nxt   = '0;
          gap_nxt   = '0;
          stage_nxt = '0;
          case (rx_data)
            OP_SET_FG, OP_SET_BG: begin
              left_nxt  = 3'd2;
              state_nxt = ST_PAYLOAD;
            end
            OP_SET_BOX: begin
              left_nxt  = 3'd4;
              state_nxt = ST_PAYLOAD;
            end
            OP_CLEAR: begin
              fg_nxt      = DEF_FG;
              bg_nxt      = DEF_BG;
              box_nxt     = DEF_BOX;
              pending_nxt = 1'b1;
            end
            default: error_nxt = 1'b1;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          stage_nxt = bytes_c;
          gap_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          left_nxt  = left - 3'd1;
          if (left == 3'd1) begin
            state_nxt   = ST_IDLE;
            pending_nxt = 1'b1;
            case (op)
              OP_SET_FG: fg_nxt = {bytes_c[0], bytes_c[1][7:4]};
              OP_SET_BG: bg_nxt = {bytes_c[0], bytes_c[1][7:4]};
              default:   box_nxt = '{x0: bytes_c[0], y0: bytes_c[1],
                                     x1: bytes_c[2], y1: bytes_c[3]};
            endcase
          end
        end else if (gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          error_nxt = 1'b1;
          left_nxt  = '0;
          stage_nxt = '0;
        end else begin
          gap_nxt = gap + GAP_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/vga_pixel_gen.sv
// VGA colour stage: registered RGB for a filled box over a background, with
// syncs realigned to the pixel and live settings committed at frame start.
module vga_pixel_gen
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic            clk,
  input logic            rst_n,
  vga_pixel_gen_if.slave bus
);

  rgb_t       live_fg, live_bg, shadow_fg, shadow_bg;
  box_t       live_box, shadow_box;
  logic       pending, busy, error;
  logic       commit_c, active_c;
  logic [7:0] bx_c, by_c;
  rgb_t       pix_c;

  assign commit_c = pending && (bus.h_count == '0) && (bus.v_count == '0);

  vga_cmd_decoder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (bus.rx_data),
    .rx_valid   (bus.rx_valid),
    .commit_c   (commit_c),
    .shadow_fg  (shadow_fg),
    .shadow_bg  (shadow_bg),
    .shadow_box (shadow_box),
    .pending    (pending),
    .busy       (busy),
    .error      (error)
  );

  assign bus.cmd_busy  = busy;
  assign bus.cmd_error = error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_fg  <= DEF_FG;
      live_bg  <= DEF_BG;
      live_box <= DEF_BOX;
    end else if (commit_c) begin
      live_fg  <= shadow_fg;
      live_bg  <= shadow_bg;
      live_box <= shadow_box;
    end
  end

  assign active_c = (bus.h_count >= CNT_W'(H_ACT_START)) && (bus.h_count <= CNT_W'(H_ACT_END)) &&
                    (bus.v_count >= CNT_W'(V_ACT_START)) && (bus.v_count <= CNT_W'(V_ACT_END));

  // Offsets are only formed once the active test passes, so they never underflow.
  always_comb begin
    pix_c = '0;
    bx_c  = '0;
    by_c  = '0;
    if (active_c) begin
      bx_c  = 8'((bus.h_count - CNT_W'(H_ACT_START)) >> 2);
      by_c  = 8'((bus.v_count - CNT_W'(V_ACT_START)) >> 2);
      pix_c = in_box(live_box, bx_c, by_c) ? live_fg : live_bg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
      bus.red       <= '0;
      bus.green     <= '0;
      bus.blue      <= '0;
    end else begin
      bus.hsync_out <= bus.hsync_in;
      bus.vsync_out <= bus.vsync_in;
      {bus.red, bus.green, bus.blue} <= pix_c;
    end
  end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Scoreboard bench for vga_pixel_gen: driver pushes model predictions per cycle,
// monitor pops and compares the registered outputs one cycle later.
module tb_vga_pixel_gen;
  import vga_pkg::*;

  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_pixel_gen_if bus();

  vga_pixel_gen #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: colours as 12-bit values, box as plain integers.
  int m_fg, m_bg, m_x0, m_y0, m_x1, m_y1;
  int s_fg, s_bg, s_x0, s_y0, s_x1, s_y1;
  bit m_pending;
  int m_left, m_op, m_gap;
  int m_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fg = 'hFFF; m_bg = 0; m_x0 = 0; m_y0 = 0; m_x1 = 159; m_y1 = 119;
    s_fg = 'hFFF; s_bg = 0; s_x0 = 0; s_y0 = 0; s_x1 = 159; s_y1 = 119;
    m_pending = 0; m_left = 0; m_op = 0; m_gap = 0;
    m_bytes.delete();
  endtask

  function automatic int model_pixel(input int h, input int v);
    int cx, cy;
    if (h < 144 || h > 783 || v < 35 || v > 514) return 0;
    cx = (h - 144) / 4;
    cy = (v - 35) / 4;
    if (cx >= m_x0 && cx <= m_x1 && cy >= m_y0 && cy <= m_y1) return m_fg;
    return m_bg;
  endfunction

  task automatic model_rx(input logic rxv, input logic [7:0] rxd, output logic err);
    err = 1'b0;
    if (m_left == 0) begin
      if (rxv) begin
        case (int'(rxd))
          1, 2: begin m_op = int'(rxd); m_left = 2; m_gap = 0; m_bytes.delete(); end
          3:    begin m_op = 3; m_left = 4; m_gap = 0; m_bytes.delete(); end
          4: begin
            s_fg = 'hFFF; s_bg = 0; s_x0 = 0; s_y0 = 0; s_x1 = 159; s_y1 = 119;
            m_pending = 1;
          end
          default: err = 1'b1;
        endcase
      end
    end else if (rxv) begin
      m_bytes.push_back(int'(rxd));
      m_gap = 0;
      m_left--;
      if (m_left == 0) begin
        if (m_op == 1)      s_fg = m_bytes[0] * 16 + m_bytes[1] / 16;
        else if (m_op == 2) s_bg = m_bytes[0] * 16 + m_bytes[1] / 16;
        else begin
          s_x0 = m_bytes[0]; s_y0 = m_bytes[1]; s_x1 = m_bytes[2]; s_y1 = m_bytes[3];
        end
        m_pending = 1;
      end
    end else begin
      m_gap++;
      if (m_gap == TO) begin
        err = 1'b1;
        m_left = 0;
        m_bytes.delete();
      end
    end
  endtask

  // One pixel-clock cycle of stimulus plus its predicted registered response.
  task automatic drive(input int h, input int v, input logic rxv, input logic [7:0] rxd);
    exp_t e;
    logic hs, vs, err;
    @(negedge clk);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    bus.h_count  = 16'(h);
    bus.v_count  = 16'(v);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
    e.rgb = 12'(model_pixel(h, v));
    e.hs  = hs;
    e.vs  = vs;
    if (h == 0 && v == 0 && m_pending) begin
      m_fg = s_fg; m_bg = s_bg; m_x0 = s_x0; m_y0 = s_y0; m_x1 = s_x1; m_y1 = s_y1;
      m_pending = 0;
    end
    model_rx(rxv, rxd, err);
    e.err  = err;
    e.busy = (m_left != 0);
    q.push_back(e);
  endtask

  task automatic pix(input int x, input int y);
    drive(x + 144, y + 35, 1'b0, 8'h00);
  endtask

  task automatic frame();
    drive(0, 0, 1'b0, 8'h00);
  endtask

  // Random position, mostly inside the active area, never the frame-start point.
  task automatic idle(input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00);
    int h, v;
    if ($urandom_range(0, 9) < 7) begin
      h = $urandom_range(144, 783);
      v = $urandom_range(35, 514);
    end else begin
      h = $urandom_range(1, 799);
      v = $urandom_range(0, 524);
    end
    drive(h, v, rxv, rxd);
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input int n, input int maxgap);
    logic [7:0] b[5];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) idle();
      idle(1'b1, b[i]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'h0);
    check({tag, "_hsync"}, 32'(bus.hsync_out), 32'h0);
    check({tag, "_vsync"}, 32'(bus.vsync_out), 32'h0);
    check({tag, "_busy"}, 32'(bus.cmd_busy), 32'h0);
    check({tag, "_err"}, 32'(bus.cmd_error), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.h_count  = '0;
    bus.v_count  = '0;
    #1;
    check_zero_outputs("midreset");
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: the registered outputs settle just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e.rgb));
        check("syncs", 32'({bus.hsync_out, bus.vsync_out}), 32'({e.hs, e.vs}));
        check("cmd_busy", 32'(bus.cmd_busy), 32'(e.busy));
        check("cmd_error", 32'(bus.cmd_error), 32'(e.err));
      end
    end
  end

  initial begin
    bus.h_count = '0; bus.v_count = '0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    model_reset();
    #5;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Defaults: white box over black.
    frame();
    pix(0, 0); drive(100, 40, 1'b0, 8'h00); pix(639, 479); pix(636, 476); pix(640 - 4, 0);
    repeat (10) idle();

    // Colour change is held until the next frame start.
    send(8'h01, 8'hA5, 8'h30, 8'h00, 8'h00, 3, 3);
    pix(0, 0); pix(10, 10);
    frame();
    pix(0, 0); pix(100, 100); pix(639, 479);

    // Box cells 10..19 with blue background.
    send(8'h03, 8'h0A, 8'h0A, 8'h13, 8'h13, 5, 2);
    send(8'h02, 8'h00, 8'hF0, 8'h00, 8'h00, 3, 2);
    frame();
    pix(40, 40); pix(39, 40); pix(80, 80); pix(79, 79); pix(40, 39); pix(79, 80);

    // Inverted box: background everywhere.
    send(8'h03, 8'h14, 8'h00, 8'h0A, 8'h77, 5, 2);
    frame();
    pix(40, 0); pix(60, 100); repeat (10) idle();

    // Bad opcode, then a stalled payload.
    send(8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    repeat (4) idle();
    send(8'h01, 8'hA5, 8'h00, 8'h00, 8'h00, 2, 0);
    repeat (TO + 8) idle();
    frame();
    pix(0, 0); pix(60, 100);

    // Reset half-way through a box command.
    send(8'h03, 8'h01, 8'h02, 8'h00, 8'h00, 3, 1);
    do_reset();
    frame();
    pix(0, 0); pix(639, 479); pix(100, 100); idle();

    // Randomised command traffic interleaved with pixels and frame starts.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: send(8'h03, 8'($urandom_range(0, 165)), 8'($urandom_range(0, 125)),
                      8'($urandom_range(0, 165)), 8'($urandom_range(0, 125)), 5, 4);
        3, 4:    send(8'h01, 8'($urandom), 8'($urandom), 8'h00, 8'h00, 3, 4);
        5, 6:    send(8'h02, 8'($urandom), 8'($urandom), 8'h00, 8'h00, 3, 4);
        7:       send(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1, 2);
        8:       send(8'($urandom_range(5, 255)), 8'h00, 8'h00, 8'h00, 8'h00, 1, 2);
        default: frame();
      endcase
      if ($urandom_range(0, 2) == 0) frame();
      repeat ($urandom_range(2, 12)) idle();
    end
    frame();
    repeat (40) idle();

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_gen.md
Name: vga_pixel_gen

Overview:
- Colour stage directly downstream of the 25 MHz VGA horizontal/vertical counters.
- Consumes h/v count values and raw syncs, and produces registered 4-bit RGB with the syncs realigned to it.
- Draws a filled box of foreground colour over a background colour inside the 640x480 active area.
- Box geometry and colours are programmed by a byte-command stream from the UART receiver. Updates are shadowed and committed only at frame start, so the picture never tears.

Parameters:
- H_ACT_START, 144, first visible h_count.
- H_ACT_END, 783, last visible h_count.
- V_ACT_START, 35, first visible v_count.
- V_ACT_END, 514, last visible v_count.
- TIMEOUT_CYCLES, 2500000, maximum clk cycles allowed between payload bytes (100 ms at 25 MHz).

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- h_count  in  16  horizontal counter value.
- v_count  in  16  vertical counter value.
- hsync_in  in  1  raw horizontal sync.
- vsync_in  in  1  raw vertical sync.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- hsync_out  out  1  hsync_in delayed 1 cycle.
- vsync_out  out  1  vsync_in delayed 1 cycle.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- cmd_busy  out  1  high while the FSM is not IDLE.
- cmd_error  out  1  one-cycle pulse on a bad opcode or a payload timeout.

Behaviour:
- Reset values (async, rst_n=0):
  - All outputs 0.
  - Live and shadow registers: fg=12'hFFF, bg=12'h000, box x0=0, y0=0, x1=159, y1=119.
  - pending=0, FSM=IDLE.
- Pixel path, 1-cycle latency:
  - RGB and both syncs are registered from the same-cycle inputs, so they stay aligned.
  - Active when H_ACT_START<=h_count<=H_ACT_END and V_ACT_START<=v_count<=V_ACT_END.
  - Pixel coordinates: x=h_count-H_ACT_START, y=v_count-V_ACT_START.
  - Box cell coordinates: bx=x>>2 (0..159), by=y>>2 (0..119).
  - Inside box when x0<=bx<=x1 and y0<=by<=y1, all comparisons inclusive and unsigned.
  - Output: inactive -> 0; active and inside box -> fg; active otherwise -> bg.
  - x0>x1 or y0>y1 gives an empty box (whole active area is bg). Cell values above 159/119 are not clipped; they simply never match.
- Command protocol: the first byte is the opcode.
  - 0x01 SET_FG: 2 payload bytes, {R,G} then {B,xxxx}.
  - 0x02 SET_BG: same payload format as SET_FG.
  - 0x03 SET_BOX: 4 payload bytes, x0, y0, x1, y1.
  - 0x04 CLEAR: no payload; shadow is loaded with the reset defaults.
  - Any other opcode: cmd_error pulse; FSM stays IDLE.
- FSM:
  - IDLE: on rx_valid, decode the opcode and latch the payload count. CLEAR completes immediately; a valid opcode with payload goes to PAYLOAD.
  - PAYLOAD: each rx_valid stores one byte into a byte-indexed staging slot and decrements the count. After the last byte, the staged fields are written to shadow, pending=1, and the FSM returns to IDLE.
  - A gap counter resets on every rx_valid. Reaching TIMEOUT_CYCLES gives cmd_error, staging is discarded, shadow is unchanged, and the FSM returns to IDLE.
  - Bytes received in PAYLOAD are always treated as payload, never as opcodes.
- Commit:
  - Fires on the cycle where h_count==0 and v_count==0 with pending=1: live<=shadow, pending<=0.
  - A command that completes in that same cycle sets pending and is committed at the next frame start.
  - Multiple commands completing before a commit merge in shadow, last write per field wins.
- Reset mid-command: FSM, staging and pending are cleared, and live/shadow return to the defaults.
- Width rules: counts compared as 16-bit unsigned; subtraction is done only after the active test passes, so there is no underflow.

Decomposition:
- Package vga_pkg holds:
  - timing constants (H/V active bounds, H_TOTAL=800, V_TOTAL=525);
  - opcode localparams;
  - default colours and box;
  - a 12-bit rgb type and a box struct.
- One natural sub-module, vga_cmd_decoder: FSM, staging, timeout, shadow and pending, exporting shadow fields and pending.
- The top level holds the live registers, commit logic and pixel path.

Test Plan:
- Release reset, run a full frame -> h=144,v=35 gives RGB=FFF one cycle later; h=100 gives 000; hsync_out equals hsync_in delayed 1.
- Send 01 A5 30 mid-frame -> colour unchanged until the next h=0,v=0; the following frame shows RGB=A,5,3 inside the box.
- Send 03 0A 0A 13 13 and 02 00 F0 -> pixel (40,40) is fg, pixel (39,40) and pixel (80,80) are bg=0,0,F; (79,79) is fg.
- Send 03 14 00 0A 77 (x0>x1) -> whole active area is bg.
- Send opcode 0x7E -> cmd_error for 1 cycle, cmd_busy stays 0. Send 01 A5 then idle TIMEOUT_CYCLES -> cmd_error, and fg is unchanged at the next frame.
- Assert rst_n=0 after 2 of 4 SET_BOX bytes -> outputs 0 immediately; after release a full-box white frame appears and cmd_busy=0.
